// File: rtl/logic_gate_unit_pkg.sv
// Shared constants and operation encodings for the logic gate unit.
package logic_gate_unit_pkg;

    localparam int OP_W  = 3;
    localparam int RED_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_XOR  = 3'b010,
        OP_NAND = 3'b011,
        OP_NOR  = 3'b100,
        OP_XNOR = 3'b101,
        OP_NOTA = 3'b110,
        OP_PASS = 3'b111
    } gate_op_e;

endpackage

// File: rtl/logic_gate_unit_stage.sv
// One valid/ready pipeline register; it accepts new data whenever it is
// empty or its current contents are leaving downstream in the same cycle.
module gate_unit_stage #(
    parameter int                DATA_W   = 8,
    parameter logic [DATA_W-1:0] RST_DATA = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              upValid_i,
    output logic              upReady_o,
    input  logic [DATA_W-1:0] upData_i,
    output logic              dnValid_o,
    input  logic              dnReady_i,
    output logic [DATA_W-1:0] dnData_o
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q,  data_d;

    assign upReady_o = !valid_q || dnReady_i;
    assign dnValid_o = valid_q;
    assign dnData_o  = data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (upReady_o) begin
            valid_d = upValid_i;
        end
        if (upValid_i && upReady_o) begin
            data_d = upData_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= RST_DATA;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/logic_gate_unit.sv
// Two-stage bitwise logic unit with valid/ready handshakes and a saturating
// completion counter. Define LOGIC_GATE_UNIT_REDUCE_EN to add the out_red port.
module logic_gate_unit
    import logic_gate_unit_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [OP_W-1:0]  in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_zero,
`ifdef LOGIC_GATE_UNIT_REDUCE_EN
    output logic [RED_W-1:0] out_red,
`endif
    output logic [CNT_W-1:0] op_count
);

    localparam int S1_W = 2 * WIDTH + OP_W;
`ifdef LOGIC_GATE_UNIT_REDUCE_EN
    localparam int S2_W = WIDTH + 1 + RED_W;
    localparam logic [S2_W-1:0] S2_RST = {{RED_W{1'b0}}, 1'b1, {WIDTH{1'b0}}};
`else
    localparam int S2_W = WIDTH + 1;
    localparam logic [S2_W-1:0] S2_RST = {1'b1, {WIDTH{1'b0}}};
`endif

    logic             s1Valid, s2Ready;
    logic [S1_W-1:0]  s1Data;
    logic [S2_W-1:0]  s2In, s2Data;
    logic [WIDTH-1:0] s1A, s1B, result;
    logic [OP_W-1:0]  s1Op;
    logic [CNT_W-1:0] opCount_q, opCount_d;

    gate_unit_stage #(.DATA_W(S1_W), .RST_DATA('0)) u_stage1 (
        .clk       (clk),
        .rst       (rst),
        .upValid_i (in_valid),
        .upReady_o (in_ready),
        .upData_i  ({in_op, in_b, in_a}),
        .dnValid_o (s1Valid),
        .dnReady_i (s2Ready),
        .dnData_o  (s1Data)
    );

    assign {s1Op, s1B, s1A} = s1Data;

    always_comb begin
        result = '0;
        case (gate_op_e'(s1Op))
            OP_AND:  result = s1A & s1B;
            OP_OR:   result = s1A | s1B;
            OP_XOR:  result = s1A ^ s1B;
            OP_NAND: result = ~(s1A & s1B);
            OP_NOR:  result = ~(s1A | s1B);
            OP_XNOR: result = ~(s1A ^ s1B);
            OP_NOTA: result = ~s1A;
            OP_PASS: result = s1A;
            default: result = '0;
        endcase
    end

    // Flags are computed ahead of the stage-2 register so they share out_y timing.
`ifdef LOGIC_GATE_UNIT_REDUCE_EN
    assign s2In = {^result, |result, &result, ~|result, result};
`else
    assign s2In = {~|result, result};
`endif

    gate_unit_stage #(.DATA_W(S2_W), .RST_DATA(S2_RST)) u_stage2 (
        .clk       (clk),
        .rst       (rst),
        .upValid_i (s1Valid),
        .upReady_o (s2Ready),
        .upData_i  (s2In),
        .dnValid_o (out_valid),
        .dnReady_i (out_ready),
        .dnData_o  (s2Data)
    );

`ifdef LOGIC_GATE_UNIT_REDUCE_EN
    assign {out_red, out_zero, out_y} = s2Data;
`else
    assign {out_zero, out_y} = s2Data;
`endif

    always_comb begin
        opCount_d = opCount_q;
        if (out_valid && out_ready && (opCount_q != {CNT_W{1'b1}})) begin
            opCount_d = opCount_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opCount_q <= '0;
        end else begin
            opCount_q <= opCount_d;
        end
    end

    assign op_count = opCount_q;

endmodule

// File: tb/tb_logic_gate_unit.sv
// Scoreboard bench for logic_gate_unit; a second instance with CNT_W=4
// shares all inputs and is used to observe counter saturation.
module tb_logic_gate_unit;
    import logic_gate_unit_pkg::*;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] y;
        logic         zero;
        logic [2:0]   red;
        int           accCyc;
        bit           exactLat;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, out_ready;
    logic [W-1:0] in_a, in_b;
    logic [2:0]   in_op;
    logic         in_ready, out_valid, out_zero;
    logic [W-1:0] out_y;
    logic [15:0]  op_count;
    logic         in_ready2, out_valid2, out_zero2;
    logic [W-1:0] out_y2;
    logic [3:0]   op_count2;
`ifdef LOGIC_GATE_UNIT_REDUCE_EN
    logic [2:0]   out_red, out_red2;
`endif

    exp_t sb[$];
    int   popCycs[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    logic_gate_unit #(.WIDTH(W), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
        .out_zero(out_zero),
`ifdef LOGIC_GATE_UNIT_REDUCE_EN
        .out_red(out_red),
`endif
        .op_count(op_count)
    );

    logic_gate_unit #(.WIDTH(W), .CNT_W(4)) dutSat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .out_valid(out_valid2), .out_ready(out_ready), .out_y(out_y2),
        .out_zero(out_zero2),
`ifdef LOGIC_GATE_UNIT_REDUCE_EN
        .out_red(out_red2),
`endif
        .op_count(op_count2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] modelGate(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a ^ b;
            3'd3:    return ~(a & b);
            3'd4:    return ~(a | b);
            3'd5:    return ~(a ^ b);
            3'd6:    return ~a;
            default: return a;
        endcase
    endfunction

    // Offer one operand set, and log its expected result once it is accepted.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [2:0] op, input logic [W-1:0] expY, input bit exact);
        int   waitCyc = 0;
        bit   done = 0;
        exp_t e;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_op = op;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                e.y = expY;
                e.zero = (expY == '0);
                e.red = {^expY, |expY, &expY};
                e.accCyc = cyc;
                e.exactLat = exact;
                sb.push_back(e);
                done = 1;
            end else begin
                waitCyc++;
                if (waitCyc > 50) begin
                    checkOutput("accept_timeout", 0, 1);
                    done = 1;
                end
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_a = W'($urandom);
        in_b = W'($urandom);
        in_op = 3'($urandom);
    endtask

    task automatic waitDrain();
        int n = 0;
        while ((sb.size() != 0 || out_valid) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) checkOutput("drain_timeout", 0, 1);
    endtask

    task automatic pulseReset();
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard consumer: compare every output handshake against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checkOutput("spurious_out", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("out_y", out_y, e.y);
                checkOutput("out_zero", out_zero, e.zero);
`ifdef LOGIC_GATE_UNIT_REDUCE_EN
                checkOutput("out_red", out_red, e.red);
`endif
                if (e.exactLat) checkOutput("latency", cyc - e.accCyc, 2);
                popCycs.push_back(cyc);
            end
        end
    end

    initial begin
        logic [W-1:0] sweepExp[8];
        logic [W-1:0] ra, rb, heldY;
        logic [2:0]   rop;
        logic [W-1:0] itemA[3], itemB[3];
        logic [2:0]   itemOp[3];
        int           p0, acc;

        sweepExp = '{8'h30, 8'hFC, 8'hCC, 8'hCF, 8'h03, 8'h33, 8'h0F, 8'hF0};
        rst = 1'b1;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        in_op = '0;
        out_ready = 1'b0;
        #1;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_out_y", out_y, 0);
        checkOutput("rst_out_zero", out_zero, 1);
        checkOutput("rst_op_count", op_count, 0);
        #12;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] op sweep");
        out_ready = 1'b1;
        for (int op = 0; op < 8; op++) applyStimulus(8'hF0, 8'h3C, 3'(op), sweepExp[op], 1);
        waitDrain();
        checkOutput("sweep_count", op_count, 8);

        $display("[TB] back-to-back");
        pulseReset();
        p0 = popCycs.size();
        for (int i = 0; i < 4; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rop = 3'($urandom);
            applyStimulus(ra, rb, rop, modelGate(rop, ra, rb), 1);
        end
        waitDrain();
        checkOutput("b2b_pops", popCycs.size() - p0, 4);
        if (popCycs.size() - p0 == 4) checkOutput("b2b_consecutive", popCycs[p0 + 3] - popCycs[p0], 3);
        checkOutput("b2b_count", op_count, 4);

        $display("[TB] backpressure");
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            itemA[i] = W'($urandom);
            itemB[i] = W'($urandom);
            itemOp[i] = 3'($urandom);
        end
        acc = 0;
        heldY = '0;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_a = itemA[acc];
            in_b = itemB[acc];
            in_op = itemOp[acc];
            @(negedge clk);
            if (out_valid && sb.size() != 0) checkOutput("stall_held_y", out_y, sb[0].y);
            if (in_ready && acc < 2) begin
                heldY = modelGate(itemOp[acc], itemA[acc], itemB[acc]);
                sb.push_back('{heldY, heldY == '0, {^heldY, |heldY, &heldY}, cyc, 1'b0});
                acc++;
            end else if (in_ready) begin
                checkOutput("stall_in_ready", in_ready, 0);
            end
            @(posedge clk);
            #1;
        end
        checkOutput("stall_accepted", acc, 2);
        checkOutput("stall_in_ready_low", in_ready, 0);
        checkOutput("stall_out_valid", out_valid, 1);
        out_ready = 1'b1;
        applyStimulus(itemA[2], itemB[2], itemOp[2], modelGate(itemOp[2], itemA[2], itemB[2]), 0);
        waitDrain();

        $display("[TB] reset mid-flight");
        out_ready = 1'b0;
        applyStimulus(8'h12, 8'h34, OP_OR, 8'h36, 0);
        applyStimulus(8'h56, 8'h78, OP_AND, 8'h50, 0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst_out_valid", out_valid, 0);
        checkOutput("midrst_op_count", op_count, 0);
        checkOutput("midrst_in_ready", in_ready, 1);
        checkOutput("midrst_out_zero", out_zero, 1);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checkOutput("post_rst_silent", out_valid, 0);
        end
        @(posedge clk);
        #1;

        $display("[TB] zero and reduce");
        applyStimulus(8'h55, 8'h55, OP_XOR, modelGate(OP_XOR, 8'h55, 8'h55), 1);
        applyStimulus(8'h07, 8'hA5, OP_PASS, modelGate(OP_PASS, 8'h07, 8'hA5), 1);
        waitDrain();

        $display("[TB] counter saturation");
        pulseReset();
        for (int i = 0; i < 20; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rop = 3'($urandom);
            applyStimulus(ra, rb, rop, modelGate(rop, ra, rb), 1);
        end
        waitDrain();
        checkOutput("sat_count_cnt4", op_count2, 4'hF);
        checkOutput("sat_count_cnt16", op_count, 20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
